alu8_seq: RTL
=============

# alu8_seq

Two-pass sequencer that runs 8-bit operations on the shared 4-bit `alu` datapath, one nibble per cycle. It latches an 8-bit request and drives the low nibble, then the high nibble, through the ALU. For arithmetic ops it chains the low-nibble carry into the high-nibble carry-in, and it assembles the 8-bit result and flags. It sits between the register file/control unit and the `alu` instance; the `alu` itself is instantiated alongside and wired to the `alu_*` ports.

## Interface
Parameters:
- none; the data width is fixed at 8 bits, split into two 4-bit nibbles.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  ALU opcode, passed unchanged to `alu_op`. `op[2]=0` is the arithmetic (sum) path; `op[2]=1` is the logic path.
- `a`, `b`  in  8 each  operands; latched when `start` is accepted.
- `cin`  in  1  carry-in for the low nibble; latched when `start` is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `result`  out  8  registered 8-bit result.
- `zero`, `carry`, `sign`  out  1 each  registered flags for `result`.
- `alu_a`, `alu_b`  out  4 each  nibble operands driven to the `alu`.
- `alu_cin`  out  1  carry-in driven to the `alu`.
- `alu_op`  out  3  opcode driven to the `alu`.
- `alu_r`  in  4  nibble result returned by the `alu`.
- `alu_carry`  in  1  carry-out returned by the `alu`.

## Operation
States: IDLE, LOW, HIGH, DONE.

- **IDLE**
  - Drives all `alu_*` outputs to 0.
  - On `start=1`: latch `a`, `b`, `cin`, `op` into internal registers, then go to LOW.
  - On `start=0`: stay in IDLE.
- **LOW**
  - Drives `alu_a=a_q[3:0]`, `alu_b=b_q[3:0]`, `alu_cin=cin_q`, `alu_op=op_q`.
  - At the clock edge, captures `alu_r` into an internal `lo_q` and `alu_carry` into `c_lo_q`, then goes to HIGH.
- **HIGH**
  - Drives `alu_a=a_q[7:4]`, `alu_b=b_q[7:4]`, `alu_op=op_q`.
  - `alu_cin = c_lo_q` when `op_q[2]=0`, otherwise 0.
  - At the clock edge, loads `result={alu_r, lo_q}`, then goes to DONE.
  - Flags loaded at the same edge:
    - `carry = alu_carry` if `op_q[2]=0`, else 0.
    - `zero = ({alu_r, lo_q} == 8'h00)`.
    - `sign = alu_r[3]`.
- **DONE**
  - `done=1` for exactly this cycle; `alu_*` outputs are 0.
  - Goes to IDLE unconditionally.

Behaviour rules:
- `start` is ignored in LOW, HIGH and DONE. There is no queueing.
- `a`, `b`, `cin` and `op` may change after acceptance without affecting the operation in flight.
- `result` and the flags change only at the HIGH→DONE edge. They hold their values otherwise, including through IDLE, until the next operation completes.
- The ALU's combinational flag outputs are not used; all flags are recomputed over 8 bits.
- Arithmetic wrap-around is modulo 256; the overflow out of bit 7 appears only on `carry`.

## Timing
- Reset (asynchronous): state=IDLE and every output is 0: `busy`, `done`, `result`, `zero`, `carry`, `sign`, all `alu_*`. The internal `lo_q` and `c_lo_q` are also cleared.
- Reset asserted mid-operation aborts the operation; no `done` is produced and `result` is cleared.
- Latency, for `start` sampled high at edge k:
  - LOW during cycle k..k+1.
  - HIGH during cycle k+1..k+2.
  - `result` valid and `done=1` during cycle k+2..k+3.
  - Back in IDLE after edge k+3.
- Throughput: at most one operation per 4 cycles. `start` held continuously high starts a new operation at every IDLE visit.
- `busy` rises at edge k and falls at edge k+3.
- `alu_*` outputs are registered-state decodes and are stable for the whole LOW/HIGH cycle. The `alu` is purely combinational, so its outputs settle within the same cycle.

## Test plan
Tests 1–4 bind a behavioural model of the `alu` to the `alu_*` ports.
1. **8-bit add:** `op=3'b000`, `a=8'h3C`, `b=8'h05`, `cin=0`, pulse `start` → `done` 3 cycles later; `result=8'h41`, `zero=0`, `carry=0`, `sign=0`. The carry from the low nibble must appear on `alu_cin` during HIGH.
2. **Wrap-around:** `op=3'b000`, `a=8'hFF`, `b=8'h01`, `cin=0` → `result=8'h00`, `zero=1`, `carry=1`, `sign=0`. Also `a=8'h7F`, `b=8'h01` → `result=8'h80`, `sign=1`, `carry=0`.
3. **Logic op:** `op[2]=1`, `a=8'hA5`, `b=8'h0F` → `alu_cin=0` in both LOW and HIGH; `result` equals the model's nibble outputs concatenated; `carry=0`.
4. **`start` while busy:** pulse `start` again in LOW, HIGH and DONE with different operands → ignored. Exactly one `done`, and `result` matches the first operands only.
5. **Reset during HIGH:** assert `reset` asynchronously mid-cycle → all outputs read 0 immediately and no `done` is produced. After release, a new `start` completes normally in 3 cycles.
6. **Back-to-back with `start` held high:** `done` pulses every 4 cycles, `busy` is low for exactly one cycle between operations, and `result` is stable between updates.

Source files
------------

// File: rtl/alu8_seq.sv
// alu8_seq: runs an 8-bit operation as two nibble passes through a shared
// 4-bit combinational alu, chaining the low-nibble carry for arithmetic ops.
module alu8_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry,
    output logic       sign,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_r,
    input  logic       alu_carry
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] a_q, b_q;
    logic              cin_q;
    logic [OP_W-1:0]   op_q;
    logic [NIB_W-1:0]  lo_q;
    logic              c_lo_q;
    logic [DATA_W-1:0] result_next;

    assign result_next = {alu_r, lo_q};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded alu drive, busy and done.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_cin    = 1'b0;
        alu_op     = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                busy       = 1'b1;
                alu_a      = a_q[NIB_W-1:0];
                alu_b      = b_q[NIB_W-1:0];
                alu_cin    = cin_q;
                alu_op     = op_q;
                state_next = S_HIGH;
            end
            S_HIGH: begin
                busy       = 1'b1;
                alu_a      = a_q[DATA_W-1:NIB_W];
                alu_b      = b_q[DATA_W-1:NIB_W];
                alu_cin    = op_q[2] ? 1'b0 : c_lo_q;
                alu_op     = op_q;
                state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request latch, low-nibble capture and 8-bit result/flag assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            op_q   <= '0;
            lo_q   <= '0;
            c_lo_q <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            sign   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
                        op_q  <= op;
                    end
                end
                S_LOW: begin
                    lo_q   <= alu_r;
                    c_lo_q <= alu_carry;
                end
                S_HIGH: begin
                    result <= result_next;
                    zero   <= (result_next == 8'h00);
                    carry  <= op_q[2] ? 1'b0 : alu_carry;
                    sign   <= alu_r[NIB_W-1];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
